// File: rtl/ddfs_sweep_ctrl.sv
// Frequency-word sequencer for the ddfs phase accumulator: single, repeating and
// triangle sweeps between f_start and f_stop with a programmable dwell per word.
module ddfs_sweep_ctrl #(
  parameter int FW = 23,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [1:0]    mode,
  input  logic [FW-1:0] f_start,
  input  logic [FW-1:0] f_stop,
  input  logic [FW-1:0] f_step,
  input  logic [DW-1:0] dwell,
  output logic [FW-1:0] fcontrol,
  output logic          fstrobe,
  output logic          busy,
  output logic          done
);

  typedef enum logic {IDLE, DWELL} state_t;

  state_t        state_reg;
  logic [DW-1:0] cnt_reg;
  logic [DW-1:0] dwell_reg;
  logic [FW-1:0] start_reg;
  logic [FW-1:0] stop_reg;
  logic [FW-1:0] step_reg;
  logic [FW-1:0] tgt_reg;
  logic [1:0]    mode_reg;
  logic          up_reg;

  logic [FW:0]   sum;
  logic [FW:0]   diff;
  logic [FW-1:0] flip_tgt;
  logic [FW-1:0] fwd_word;
  logic [FW-1:0] flip_word;

  // One extra bit catches overflow past 2^FW-1 and the borrow below 0.
  function automatic logic [FW-1:0] clamp_step(input logic up, input logic [FW-1:0] tgt,
                                              input logic [FW:0] s, input logic [FW:0] d);
    if (up)
      return (s > {1'b0, tgt}) ? tgt : s[FW-1:0];
    else
      return (d[FW] || (d[FW-1:0] < tgt)) ? tgt : d[FW-1:0];
  endfunction

  assign sum       = {1'b0, fcontrol} + {1'b0, step_reg};
  assign diff      = {1'b0, fcontrol} - {1'b0, step_reg};
  assign flip_tgt  = (tgt_reg == stop_reg) ? start_reg : stop_reg;
  assign fwd_word  = clamp_step(up_reg, tgt_reg, sum, diff);
  assign flip_word = clamp_step(~up_reg, flip_tgt, sum, diff);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      dwell_reg <= '0;
      start_reg <= '0;
      stop_reg  <= '0;
      step_reg  <= '0;
      tgt_reg   <= '0;
      mode_reg  <= '0;
      up_reg    <= 1'b1;
      fcontrol  <= '0;
      fstrobe   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      fstrobe <= 1'b0;
      done    <= 1'b0;
      if (abort) begin
        state_reg <= IDLE;
        busy      <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start) begin
              start_reg <= f_start;
              stop_reg  <= f_stop;
              step_reg  <= f_step;
              dwell_reg <= dwell;
              mode_reg  <= mode;
              tgt_reg   <= f_stop;
              up_reg    <= (f_stop >= f_start);
              fcontrol  <= f_start;
              fstrobe   <= 1'b1;
              busy      <= 1'b1;
              cnt_reg   <= dwell;
              state_reg <= DWELL;
            end
          end
          DWELL: begin
            if (cnt_reg != '0) begin
              cnt_reg <= cnt_reg - 1'b1;
            end else begin
              cnt_reg <= dwell_reg;
              if (fcontrol == tgt_reg) begin
                case (mode_reg)
                  2'b01: begin
                    fcontrol <= start_reg;
                    fstrobe  <= 1'b1;
                  end
                  2'b10: begin
                    up_reg   <= ~up_reg;
                    tgt_reg  <= flip_tgt;
                    fcontrol <= flip_word;
                    fstrobe  <= 1'b1;
                  end
                  default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                  end
                endcase
              end else if (step_reg != '0) begin
                // A zero step never reaches a distinct target: hold the tone silently.
                fcontrol <= fwd_word;
                fstrobe  <= 1'b1;
              end
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ddfs_sweep_ctrl.sv
// Directed and randomized sweeps checked cycle-by-cycle against a word-list model
// built from the sweep rules with plain integer arithmetic.
module tb_ddfs_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [22:0] f_start = '0;
  logic [22:0] f_stop = '0;
  logic [22:0] f_step = '0;
  logic [15:0] dwell = '0;
  logic [22:0] fcontrol;
  logic        fstrobe;
  logic        busy;
  logic        done;

  int vectors = 0;
  int miscompares = 0;

  longint q_f[$];
  bit     q_s[$];
  bit     q_b[$];
  bit     q_d[$];

  ddfs_sweep_ctrl #(.FW(23), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell),
    .fcontrol(fcontrol), .fstrobe(fstrobe), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic longint toward(input longint w, input longint t, input longint st);
    if (t > w) return (w + st > t) ? t : w + st;
    else       return (w - st < t) ? t : w - st;
  endfunction

  function automatic void push(input longint f, input bit s, input bit b, input bit d);
    q_f.push_back(f); q_s.push_back(s); q_b.push_back(b); q_d.push_back(d);
  endfunction

  // Expected per-cycle observations starting right after the accepting start edge.
  function automatic int build(input int md, input longint s, input longint e,
                               input longint st, input longint dw, input int maxc);
    longint w = s;
    longint tgt = e;
    bit stb = 1'b1;
    bit fin = 1'b0;
    q_f.delete(); q_s.delete(); q_b.delete(); q_d.delete();
    while (!fin && q_f.size() < maxc) begin
      for (longint c = 0; c <= dw; c++) push(w, stb && (c == 0), 1'b1, 1'b0);
      if (w == tgt) begin
        if (md == 1) begin
          w = s; stb = 1'b1;
        end else if (md == 2) begin
          tgt = (tgt == e) ? s : e;
          w = toward(w, tgt, st); stb = 1'b1;
        end else begin
          push(w, 1'b0, 1'b0, 1'b1);
          push(w, 1'b0, 1'b0, 1'b0);
          fin = 1'b1;
        end
      end else if (st == 0) begin
        stb = 1'b0;
      end else begin
        w = toward(w, tgt, st); stb = 1'b1;
      end
    end
    return fin ? q_f.size() : maxc;
  endfunction

  task automatic check_cycle(input int j);
    chk("fcontrol", 32'(fcontrol), 32'(q_f[j]));
    chk("fstrobe", 32'(fstrobe), 32'(q_s[j]));
    chk("busy", 32'(busy), 32'(q_b[j]));
    chk("done", 32'(done), 32'(q_d[j]));
  endtask

  task automatic launch(input int md, input longint s, input longint e,
                        input longint st, input longint dw);
    mode = 2'(md); f_start = 23'(s); f_stop = 23'(e); f_step = 23'(st); dwell = 16'(dw);
    start = 1'b1;
    tick();
    start = 1'b0;
    mode = 2'($urandom); f_start = 23'($urandom); f_stop = 23'($urandom);
    f_step = 23'($urandom); dwell = 16'($urandom);
  endtask

  task automatic run(input int md, input longint s, input longint e, input longint st,
                     input longint dw, input int maxc, input bit inj);
    int n;
    longint last;
    n = build(md, s, e, st, dw, maxc);
    launch(md, s, e, st, dw);
    for (int j = 0; j < n; j++) begin
      check_cycle(j);
      start = inj && q_b[j] && (j % 5 == 2);
      if (j < n - 1) tick();
    end
    start = 1'b0;
    last = q_f[n-1];
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_fcontrol", 32'(fcontrol), 32'(last));
    chk("abort_fstrobe", 32'(fstrobe), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("startabort_busy", 32'(busy), 32'd0);
    chk("startabort_fcontrol", 32'(fcontrol), 32'(last));
    chk("startabort_fstrobe", 32'(fstrobe), 32'd0);
    tick();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_fcontrol", 32'(fcontrol), 32'(last));
    $display("run mode=%0d start=%h stop=%h step=%h dwell=%0d cycles=%0d",
             md, s, e, st, dw, n);
  endtask

  initial begin
    int n;
    tick();
    chk("reset_fcontrol", 32'(fcontrol), 32'd0);
    chk("reset_fstrobe", 32'(fstrobe), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();

    run(0, 'h100, 'h130, 'h10, 2, 1000, 1'b1);
    run(0, 'h100, 'h125, 'h10, 0, 1000, 1'b0);
    run(2, 'h200, 'h100, 'h80, 0, 14, 1'b1);
    run(0, 'h7FFF00, 'h7FFFFF, 'h80, 1, 1000, 1'b0);
    run(1, 'h100, 'h140, 'h20, 3, 10, 1'b1);
    run(0, 'h55, 'h55, 'h10, 2, 1000, 1'b0);
    run(1, 'h300, 'h300, 'h10, 1, 9, 1'b0);
    run(0, 'h40, 'h90, 0, 1, 12, 1'b1);
    run(0, 'h30, 'h0, 'h40, 0, 1000, 1'b0);

    // Reset asserted between edges in the middle of a sweep.
    n = build(1, 'h300, 'h380, 'h10, 1, 100);
    launch(1, 'h300, 'h380, 'h10, 1);
    for (int j = 0; j < 5; j++) begin
      check_cycle(j);
      tick();
    end
    #3 rst_n = 1'b0;
    #1;
    chk("midreset_fcontrol", 32'(fcontrol), 32'd0);
    chk("midreset_fstrobe", 32'(fstrobe), 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_done", 32'(done), 32'd0);
    tick();
    chk("inreset_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("postreset_busy", 32'(busy), 32'd0);
    chk("postreset_fcontrol", 32'(fcontrol), 32'd0);
    run(0, 'h10, 'h40, 'h18, 1, 1000, 1'b0);

    for (int t = 0; t < 40; t++) begin
      int md, maxc;
      longint dw, r, s, e, st;
      bit up;
      md = int'($urandom_range(0, 3));
      dw = longint'($urandom_range(0, 3));
      r  = longint'($urandom_range(0, 'h300));
      up = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0)
        s = up ? 'h7FFFFF - longint'($urandom_range(0, 'h300)) : longint'($urandom_range(0, 'h300));
      else
        s = longint'($urandom_range(0, 'h7FFFFF));
      e = up ? s + r : s - r;
      if (e > 'h7FFFFF) e = 'h7FFFFF;
      if (e < 0) e = 0;
      st = ($urandom_range(0, 7) == 0) ? 0 : r / 8 + longint'($urandom_range(1, 'h80));
      if (md == 0 || md == 3) maxc = (st == 0) ? 30 : 1000;
      else maxc = int'($urandom_range(8, 40));
      run(md, s, e, st, dw, maxc, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
